// File: rtl/sigmoid_inv_search_pkg.sv
// rtl/sigmoid_inv_search_pkg.sv - shared types, defaults and PWL sigmoid tables
package sigmoid_inv_search_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_CMP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [15:0] X_MIN_DEF = 16'hF800;
    localparam logic [15:0] X_MAX_DEF = 16'h0800;
    localparam int          ITER_DEF  = 12;
    localparam logic [15:0] SAT_TH    = 16'h0101;

    // s(x) = bias + ((x - bp) * slope) >>> 8 on the segment starting at bp, clamped to 0..SAT_TH
    localparam int NSEG = 5;
    localparam logic signed [16:0] PWL_BP [NSEG] = '{-17'sd2048, -17'sd1024, -17'sd257, 17'sd256, 17'sd1024};
    localparam logic        [7:0]  PWL_SLOPE [NSEG] = '{8'd4, 8'd12, 8'd64, 8'd12, 8'd7};
    localparam logic        [15:0] PWL_BIAS  [NSEG] = '{16'd0, 16'd16, 16'd66, 16'd195, 16'd231};

endpackage

// File: rtl/sigmoid_inv_search_pwl_core.sv
// rtl/sigmoid_inv_search_pwl_core.sv - registered Q8.8 piecewise-linear sigmoid evaluator
module sigmoid_pwl_core
    import sigmoid_inv_search_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [16:0] x,
    output logic        [15:0] s_q
);

    localparam logic signed [25:0] SAT_26 = 26'sh101;

    logic signed [16:0] bp_sel;
    logic        [7:0]  slope_sel;
    logic        [15:0] bias_sel;
    logic signed [25:0] dx;
    logic signed [25:0] prod;
    logic signed [25:0] val;
    logic        [15:0] s_d;

    always_comb begin
        bp_sel    = PWL_BP[0];
        slope_sel = PWL_SLOPE[0];
        bias_sel  = PWL_BIAS[0];
        for (int i = 1; i < NSEG; i++) begin
            if (x >= PWL_BP[i]) begin
                bp_sel    = PWL_BP[i];
                slope_sel = PWL_SLOPE[i];
                bias_sel  = PWL_BIAS[i];
            end
        end
        dx   = {{9{x[16]}}, x} - {{9{bp_sel[16]}}, bp_sel};
        prod = dx * $signed({18'd0, slope_sel});
        val  = $signed({10'd0, bias_sel}) + (prod >>> 8);
        s_d  = val[15:0];
        if (val[25]) begin
            s_d = 16'h0000;
        end else if (val > SAT_26) begin
            s_d = SAT_TH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q <= 16'h0000;
        end else begin
            s_q <= s_d;
        end
    end

endmodule

// File: rtl/sigmoid_inv_search.sv
// rtl/sigmoid_inv_search.sv - bisection search for the smallest x with s(x) >= target
module sigmoid_inv_search
    import sigmoid_inv_search_pkg::*;
#(
    parameter logic [15:0] X_MIN = X_MIN_DEF,
    parameter logic [15:0] X_MAX = X_MAX_DEF,
    parameter int          ITER  = ITER_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] y_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] x_out,
    output logic        sat
);

    localparam int CNT_W = $clog2(ITER + 1);
    localparam logic signed [16:0] LO_INIT = {X_MIN[15], X_MIN};
    localparam logic signed [16:0] HI_INIT = {X_MAX[15], X_MAX};

    state_t state_q, state_d;

    logic signed [16:0] lo_q, lo_d, hi_q, hi_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        y_q, y_d;
    logic [15:0]        x_q, x_d;
    logic               sat_q, sat_d;

    logic signed [16:0] sum;
    logic signed [16:0] mid;
    logic [15:0]        s_mid;
    logic               hit;
    logic               last;
    logic               y_is_sat;

    // mid is held steady across EVAL and CMP, so the evaluator's registered output lines up with it in CMP
    assign sum      = lo_q + hi_q;
    assign mid      = sum >>> 1;
    assign hit      = (s_mid >= y_q);
    assign last     = (cnt_q == CNT_W'(ITER - 1));
    assign y_is_sat = (y_in == 16'h0000) || (y_in > SAT_TH);

    sigmoid_pwl_core u_pwl (
        .clk   (clk),
        .rst_n (rst),
        .x     (mid),
        .s_q   (s_mid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid) state_d = y_is_sat ? S_DONE : S_EVAL;
            S_EVAL: state_d = S_CMP;
            S_CMP:  state_d = last ? S_DONE : S_EVAL;
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
    end

    always_comb begin
        lo_d  = lo_q;
        hi_d  = hi_q;
        cnt_d = cnt_q;
        y_d   = y_q;
        x_d   = x_q;
        sat_d = sat_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    y_d = y_in;
                    if (y_in == 16'h0000) begin
                        x_d   = X_MIN;
                        sat_d = 1'b1;
                    end else if (y_in > SAT_TH) begin
                        x_d   = X_MAX;
                        sat_d = 1'b1;
                    end else begin
                        lo_d  = LO_INIT;
                        hi_d  = HI_INIT;
                        cnt_d = '0;
                        sat_d = 1'b0;
                    end
                end
            end
            S_CMP: begin
                if (hit) begin
                    hi_d = mid;
                end else begin
                    lo_d = mid;
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (last) begin
                    x_d = hit ? mid[15:0] : hi_q[15:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lo_q  <= '0;
            hi_q  <= '0;
            cnt_q <= '0;
            y_q   <= 16'h0000;
            x_q   <= 16'h0000;
            sat_q <= 1'b0;
        end else begin
            lo_q  <= lo_d;
            hi_q  <= hi_d;
            cnt_q <= cnt_d;
            y_q   <= y_d;
            x_q   <= x_d;
            sat_q <= sat_d;
        end
    end

    assign x_out = x_q;
    assign sat   = sat_q;

endmodule

// File: tb/tb_sigmoid_inv_search.sv
// tb/tb_sigmoid_inv_search.sv - self-checking bench for sigmoid_inv_search
module tb_sigmoid_inv_search;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] y_in = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] x_out;
    logic        sat;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_x = 16'h0000;
    logic        exp_sat = 1'b0;

    sigmoid_inv_search dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .sat       (sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Golden PWL sigmoid, integer Q8.8
    function automatic int sig(input int x);
        int v;
        if (x >= 1024)       v = 231 + ((x - 1024) * 7) / 256;
        else if (x >= 256)   v = 195 + ((x - 256) * 12) / 256;
        else if (x >= -257)  v = 66 + (x + 257) / 4;
        else if (x >= -1024) v = 16 + ((x + 1024) * 12) / 256;
        else if (x >= -2048) v = ((x + 2048) * 4) / 256;
        else                 v = 0;
        if (v > 257) v = 257;
        return v;
    endfunction

    task automatic model_inv(input int y, output int x, output bit s);
        s = 1'b0;
        x = 2048;
        if (y == 0) begin
            x = -2048;
            s = 1'b1;
        end else if (y > 257) begin
            x = 2048;
            s = 1'b1;
        end else begin
            for (int k = 2048; k >= -2047; k--) begin
                if (sig(k) >= y) x = k;
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst && out_valid) begin
            chk("x_out_vs_model", int'(x_out), int'(exp_x));
            chk("sat_vs_model", int'(sat), int'(exp_sat));
            chk("no_ready_in_done", int'(in_ready), 0);
        end
    end

    task automatic send(input logic [15:0] y, input int hold, input bit noise, input bit reaccept,
                        output logic [15:0] xo, output logic so);
        int  n;
        int  lat;
        int  mx;
        bit  ms;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_send", int'(in_ready), 1);
        y_in     = y;
        in_valid = 1'b1;
        @(posedge clk);
        model_inv(int'(y), mx, ms);
        exp_x   = mx[15:0];
        exp_sat = ms;
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            if (noise) begin
                y_in     = 16'($urandom);
                in_valid = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        chk("latency", lat, ms ? 1 : 25);
        xo = x_out;
        so = sat;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_out_valid", int'(out_valid), 1);
            chk("hold_in_ready", int'(in_ready), 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        if (reaccept) begin
            in_valid = 1'b1;
            y_in     = 16'h0080;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("back_to_idle", int'(in_ready), 1);
        chk("out_valid_drop", int'(out_valid), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] xo;
        logic        so;
        int          mx;
        bit          ms;
        int          xs;

        // reset state
        #12;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_x_out", int'(x_out), 0);
        chk("rst_sat", int'(sat), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_release", int'(in_ready), 1);

        // pin the model with hand-computed values
        chk("model_s_m9", sig(-9), 128);
        chk("model_s_m10", sig(-10), 127);
        chk("model_s_max", sig(2048), 257);
        chk("model_s_min", sig(-2048), 0);
        model_inv(128, mx, ms);
        chk("model_inv_0080", mx, -9);
        model_inv(64, mx, ms);
        chk("model_inv_0040", mx, -257);

        send(16'h0080, 0, 1'b0, 1'b0, xo, so);
        chk("y0080_x", int'(xo), 16'hFFF7);
        chk("y0080_sat", int'(so), 0);

        send(16'h0000, 0, 1'b0, 1'b0, xo, so);
        chk("y0000_x", int'(xo), 16'hF800);
        chk("y0000_sat", int'(so), 1);

        send(16'h0200, 0, 1'b0, 1'b0, xo, so);
        chk("y0200_x", int'(xo), 16'h0800);
        chk("y0200_sat", int'(so), 1);

        send(16'h0102, 0, 1'b0, 1'b0, xo, so);
        chk("y0102_sat", int'(so), 1);
        send(16'hFFFF, 0, 1'b0, 1'b0, xo, so);
        chk("yFFFF_x", int'(xo), 16'h0800);
        send(16'h0101, 0, 1'b0, 1'b0, xo, so);
        chk("y0101_sat", int'(so), 0);

        // stall in DONE, then try to sneak a new target in on the release cycle
        send(16'h0040, 10, 1'b0, 1'b1, xo, so);
        chk("hold_x", int'(xo), 16'hFEFF);

        send(16'h0040, 0, 1'b1, 1'b0, xo, so);
        chk("noise_x", int'(xo), 16'hFEFF);

        // reset in the middle of a search
        @(negedge clk);
        chk("in_ready_pre_abort", int'(in_ready), 1);
        y_in     = 16'h0080;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (11) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_x_out", int'(x_out), 0);
        chk("abort_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_release_ready", int'(in_ready), 1);
        chk("abort_release_valid", int'(out_valid), 0);
        send(16'h00C0, 0, 1'b0, 1'b0, xo, so);
        chk("y00C0_x", int'(xo), 16'h00F7);

        // full sweep of non-saturating targets
        for (int y = 1; y <= 257; y++) begin
            send(y[15:0], 0, 1'b0, 1'b0, xo, so);
            xs = int'($signed(xo));
            chk("sweep_ge", int'(sig(xs) >= y), 1);
            chk("sweep_prev_lt", int'(sig(xs - 1) < y), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
